// File: rtl/busca_instrucao_pkg.sv
// Types and constants shared by the instruction fetch stage and its neighbours.
// The fetch FIFO carries one entrada_fila_t per delivered instruction.
package pacote_cpu;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 64;

    localparam logic [INSTR_W-1:0] NOP_PADRAO = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_W-1:0] instrucao;
        logic [PC_W-1:0]    pc;
        logic               erro;
    } entrada_fila_t;

endpackage

// File: rtl/busca_instrucao_chk.sv
// Property checker for the fetch stage: reserved slots (queued + in flight)
// must never exceed the FIFO depth.
module busca_instrucao_chk #(
    parameter int PROFUNDIDADE = 2,
    parameter int OW           = 2
) (
    input logic          clock,
    input logic          reset,
    input logic [OW-1:0] ocupacao,
    input logic [OW-1:0] em_voo
);

    localparam logic [OW:0] LIMITE = (OW+1)'(PROFUNDIDADE);

    a_reserva: assert property (@(posedge clock) disable iff (reset)
        ({1'b0, ocupacao} + {1'b0, em_voo}) <= LIMITE)
        else $error("busca_instrucao: ocupacao + em_voo above PROFUNDIDADE");

endmodule

// File: rtl/fila_instrucao.sv
// Synchronous FIFO of fetched instructions with flush; the head is read straight
// from the storage registers so the decoder never sees a combinational path.
module fila_instrucao
    import pacote_cpu::*;
#(
    parameter int PROFUNDIDADE = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  entrada_fila_t                 dado,
    input  logic                          pop,
    input  logic                          flush,
    output entrada_fila_t                 cabeca,
    output logic                          valida,
    output logic [$clog2(PROFUNDIDADE):0] ocupacao
);

    localparam int PW = $clog2(PROFUNDIDADE);
    localparam int OW = PW + 1;

    entrada_fila_t r_mem [PROFUNDIDADE];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [OW-1:0] r_ocup;
    logic          r_valida;

    logic          w_pop;
    logic [OW-1:0] w_ocup_prox;

    // Qualify pop with a valid head and compute next occupancy
    always_comb begin
        w_pop = pop & r_valida;
        if (flush) begin
            w_ocup_prox = '0;
        end else begin
            w_ocup_prox = r_ocup + OW'(push) - OW'(w_pop);
        end
    end

    // Storage, pointers and occupancy; flush wins over push and pop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                r_mem[i] <= '0;
            end
            r_rd     <= '0;
            r_wr     <= '0;
            r_ocup   <= '0;
            r_valida <= 1'b0;
        end else if (flush) begin
            r_rd     <= '0;
            r_wr     <= '0;
            r_ocup   <= '0;
            r_valida <= 1'b0;
        end else begin
            if (push) begin
                r_mem[r_wr] <= dado;
                r_wr        <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            r_ocup   <= w_ocup_prox;
            r_valida <= (w_ocup_prox != '0);
        end
    end

    assign cabeca   = r_mem[r_rd];
    assign valida   = r_valida;
    assign ocupacao = r_ocup;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: issues PC reads to a synchronous memory, tracks them in a
// tag pipeline and queues {instruction, pc, range error} for the decoder.
module busca_instrucao
    import pacote_cpu::*;
#(
    parameter int                 LATENCIA     = 1,
    parameter int                 PROFUNDIDADE = 2,
    parameter int                 MEM_ADDR_W   = 10,
    parameter logic [INSTR_W-1:0] NOP          = NOP_PADRAO
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PC_W-1:0]       endereco,
    input  logic                  endereco_valido,
    output logic                  endereco_pronto,
    output logic                  mem_ler,
    output logic [MEM_ADDR_W-1:0] mem_endereco,
    input  logic [INSTR_W-1:0]    mem_dado,
    output logic [INSTR_W-1:0]    instrucao,
    output logic [PC_W-1:0]       instrucao_pc,
    output logic                  instrucao_valida,
    input  logic                  instrucao_pronta,
    input  logic                  descarta,
    output logic                  erro_alinhamento
);

    localparam int          OW     = $clog2(PROFUNDIDADE) + 1;
    localparam logic [OW:0] LIMITE = (OW+1)'(PROFUNDIDADE);

    logic            r_tag_v    [LATENCIA];
    logic [PC_W-1:0] r_tag_pc   [LATENCIA];
    logic            r_tag_erro [LATENCIA];
    logic [OW-1:0]   r_em_voo;
    logic [OW-1:0]   r_descartar;

    logic [OW-1:0]   w_ocupacao;
    logic [OW:0]     w_reservado;
    logic            w_fora;
    logic            w_aceita;
    logic            w_resposta;
    logic            w_push;
    entrada_fila_t   w_entrada;
    entrada_fila_t   w_cabeca;

    // Handshake, memory request and response formation; slots are reserved at issue
    always_comb begin
        w_fora          = (endereco[PC_W-1:MEM_ADDR_W] != '0);
        w_reservado     = {1'b0, w_ocupacao} + {1'b0, r_em_voo};
        endereco_pronto = !reset && !descarta && (w_reservado < LIMITE);
        w_aceita        = endereco_valido && endereco_pronto;
        mem_ler         = w_aceita;
        mem_endereco    = endereco[MEM_ADDR_W-1:0];
        w_resposta      = r_tag_v[LATENCIA-1];
        w_push          = w_resposta && !descarta && (r_descartar == '0);
        w_entrada.instrucao = r_tag_erro[LATENCIA-1] ? NOP : mem_dado;
        w_entrada.pc        = r_tag_pc[LATENCIA-1];
        w_entrada.erro      = r_tag_erro[LATENCIA-1];
    end

    // Tag pipeline aligned with the memory read latency
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LATENCIA; k++) begin
                r_tag_v[k]    <= 1'b0;
                r_tag_pc[k]   <= '0;
                r_tag_erro[k] <= 1'b0;
            end
        end else begin
            r_tag_v[0]    <= w_aceita;
            r_tag_pc[0]   <= endereco;
            r_tag_erro[0] <= w_fora;
            for (int k = 1; k < LATENCIA; k++) begin
                r_tag_v[k]    <= r_tag_v[k-1];
                r_tag_pc[k]   <= r_tag_pc[k-1];
                r_tag_erro[k] <= r_tag_erro[k-1];
            end
        end
    end

    // In-flight count and the number of stale responses still to be dropped after a flush
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_em_voo    <= '0;
            r_descartar <= '0;
        end else begin
            r_em_voo <= r_em_voo + OW'(w_aceita) - OW'(w_resposta);
            if (descarta) begin
                r_descartar <= r_em_voo - OW'(w_resposta);
            end else if (w_resposta && (r_descartar != '0)) begin
                r_descartar <= r_descartar - OW'(1);
            end
        end
    end

    fila_instrucao #(
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fila (
        .clock    (clock),
        .reset    (reset),
        .push     (w_push),
        .dado     (w_entrada),
        .pop      (instrucao_pronta),
        .flush    (descarta),
        .cabeca   (w_cabeca),
        .valida   (instrucao_valida),
        .ocupacao (w_ocupacao)
    );

    busca_instrucao_chk #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .OW           (OW)
    ) u_chk (
        .clock    (clock),
        .reset    (reset),
        .ocupacao (w_ocupacao),
        .em_voo   (r_em_voo)
    );

    assign instrucao        = w_cabeca.instrucao;
    assign instrucao_pc     = w_cabeca.pc;
    assign erro_alinhamento = w_cabeca.erro;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed and random bench for busca_instrucao: instance A (LATENCIA=1, PROFUNDIDADE=2)
// for the directed steps, instance B (LATENCIA=2, PROFUNDIDADE=4) for the random run.
module tb_busca_instrucao;
    import pacote_cpu::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // instance A signals
    logic        rst_a, ev_a, ep_a, ml_a, iv_a, ip_a, desc_a, erro_a;
    logic [63:0] end_a, pc_a;
    logic [9:0]  me_a;
    logic [31:0] md_a, ins_a;
    entrada_fila_t fila_a[$];
    int n_ciclo_a = 0, n_pop_a = 0, t_acc_a = -1, t_val_a = -1;

    // instance B signals
    logic        rst_b, ev_b, ep_b, ml_b, iv_b, ip_b, desc_b, erro_b;
    logic [63:0] end_b, pc_b;
    logic [9:0]  me_b;
    logic [31:0] md_b, md_b1, ins_b;
    entrada_fila_t fila_b[$];

    busca_instrucao #(.LATENCIA(1), .PROFUNDIDADE(2), .MEM_ADDR_W(10)) dut_a (
        .clock(clock), .reset(rst_a), .endereco(end_a), .endereco_valido(ev_a),
        .endereco_pronto(ep_a), .mem_ler(ml_a), .mem_endereco(me_a), .mem_dado(md_a),
        .instrucao(ins_a), .instrucao_pc(pc_a), .instrucao_valida(iv_a),
        .instrucao_pronta(ip_a), .descarta(desc_a), .erro_alinhamento(erro_a));

    busca_instrucao #(.LATENCIA(2), .PROFUNDIDADE(4), .MEM_ADDR_W(10)) dut_b (
        .clock(clock), .reset(rst_b), .endereco(end_b), .endereco_valido(ev_b),
        .endereco_pronto(ep_b), .mem_ler(ml_b), .mem_endereco(me_b), .mem_dado(md_b),
        .instrucao(ins_b), .instrucao_pc(pc_b), .instrucao_valida(iv_b),
        .instrucao_pronta(ip_b), .descarta(desc_b), .erro_alinhamento(erro_b));

    // memory models: word at address w holds A000_0000 + w
    always @(posedge clock) md_a <= 32'hA000_0000 + {22'd0, me_a};
    always @(posedge clock) begin
        md_b1 <= 32'hA000_0000 + {22'd0, me_b};
        md_b  <= md_b1;
    end

    function automatic entrada_fila_t esperado(input logic [63:0] a);
        entrada_fila_t e;
        e.pc        = a;
        e.erro      = (a[63:10] != 54'd0);
        e.instrucao = e.erro ? 32'h0000_0013 : (32'hA000_0000 + {22'd0, a[9:0]});
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one cycle of A: inputs already set after a negedge; sample, score, wait next negedge
    task automatic ciclo_a(output bit aceitou);
        entrada_fila_t e;
        #1;
        n_ciclo_a++;
        aceitou = ev_a && ep_a;
        chk("mem_ler_a", 128'(ml_a), 128'(aceitou));
        if (aceitou && t_acc_a < 0) t_acc_a = n_ciclo_a;
        if (iv_a && t_val_a < 0) t_val_a = n_ciclo_a;
        if (iv_a && ip_a) begin
            n_pop_a++;
            n_assert++;
            assert (fila_a.size() != 0) else begin
                n_fail++;
                $error("FAIL pop_sem_esperado_a: observed pc %0h expected no output", pc_a);
            end
            if (fila_a.size() != 0) begin
                e = fila_a.pop_front();
                chk("instrucao_a", 128'(ins_a), 128'(e.instrucao));
                chk("pc_a", 128'(pc_a), 128'(e.pc));
                chk("erro_a", 128'(erro_a), 128'(e.erro));
            end
        end
        if (desc_a) fila_a.delete();
        if (aceitou) begin
            chk("mem_endereco_a", 128'(me_a), 128'(end_a[9:0]));
            fila_a.push_back(esperado(end_a));
        end
        @(negedge clock);
    endtask

    task automatic ciclo_b(output bit aceitou);
        entrada_fila_t e;
        #1;
        aceitou = ev_b && ep_b;
        chk("mem_ler_b", 128'(ml_b), 128'(aceitou));
        if (iv_b && ip_b) begin
            n_assert++;
            assert (fila_b.size() != 0) else begin
                n_fail++;
                $error("FAIL pop_sem_esperado_b: observed pc %0h expected no output", pc_b);
            end
            if (fila_b.size() != 0) begin
                e = fila_b.pop_front();
                chk("instrucao_b", 128'(ins_b), 128'(e.instrucao));
                chk("pc_b", 128'(pc_b), 128'(e.pc));
                chk("erro_b", 128'(erro_b), 128'(e.erro));
            end
        end
        if (desc_b) fila_b.delete();
        if (aceitou) fila_b.push_back(esperado(end_b));
        chk("reservado_b", 128'(fila_b.size() <= 4), 128'(1));
        @(negedge clock);
    endtask

    task automatic stream_a(input logic [63:0] base, input int n, input int budget);
        int k = 0;
        bit ac;
        for (int c = 0; c < budget && k < n; c++) begin
            end_a = base + 64'(k);
            ev_a  = 1'b1;
            ciclo_a(ac);
            if (ac) k++;
        end
        ev_a = 1'b0;
        chk("stream_a_aceitos", 128'(k), 128'(n));
    endtask

    task automatic drena_a(input int budget);
        bit ac;
        ev_a = 1'b0;
        ip_a = 1'b1;
        for (int c = 0; c < budget && (fila_a.size() != 0 || iv_a); c++) ciclo_a(ac);
        chk("drena_a_fila", 128'(fila_a.size()), 128'(0));
        chk("drena_a_valida", 128'(iv_a), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ac;
        int k;
        int pops0;
        rst_a = 1'b1; ev_a = 1'b0; ip_a = 1'b1; desc_a = 1'b0; end_a = 64'd0;
        rst_b = 1'b1; ev_b = 1'b0; ip_b = 1'b1; desc_b = 1'b0; end_b = 64'd0;
        repeat (3) @(negedge clock);
        ev_a = 1'b1;
        #1;
        chk("reset_pronto", 128'(ep_a), 128'(0));
        chk("reset_mem_ler", 128'(ml_a), 128'(0));
        chk("reset_valida", 128'(iv_a), 128'(0));
        chk("reset_instrucao", 128'(ins_a), 128'(0));
        chk("reset_pc", 128'(pc_a), 128'(0));
        chk("reset_erro", 128'(erro_a), 128'(0));
        @(negedge clock);
        ev_a = 1'b0; rst_a = 1'b0; rst_b = 1'b0;

        // 1: stream 0..7, decoder always ready
        t_acc_a = -1; t_val_a = -1; pops0 = n_pop_a;
        ip_a = 1'b1;
        stream_a(64'd0, 8, 40);
        drena_a(20);
        chk("t1_latencia", 128'(t_val_a - t_acc_a), 128'(2));
        chk("t1_entregues", 128'(n_pop_a - pops0), 128'(8));

        // 2: back-pressure fills the FIFO, then release
        pops0 = n_pop_a;
        ip_a = 1'b0; k = 0;
        for (int c = 0; c < 6; c++) begin
            end_a = 64'd100 + 64'(k); ev_a = 1'b1;
            ciclo_a(ac);
            if (ac) k++;
        end
        chk("t2_aceitos_cheio", 128'(k), 128'(2));
        chk("t2_pronto_cheio", 128'(ep_a), 128'(0));
        chk("t2_valida_cheio", 128'(iv_a), 128'(1));
        ip_a = 1'b1;
        stream_a(64'd100 + 64'(k), 6, 40);
        drena_a(20);
        chk("t2_entregues", 128'(n_pop_a - pops0), 128'(8));

        // 3: out-of-range address
        pops0 = n_pop_a;
        stream_a(64'h400, 1, 10);
        drena_a(10);
        chk("t3_entregues", 128'(n_pop_a - pops0), 128'(1));

        // 4: flush with 10 queued and 11 arriving, then 40
        pops0 = n_pop_a;
        ip_a = 1'b0;
        stream_a(64'd10, 2, 6);
        desc_a = 1'b1;
        ciclo_a(ac);
        desc_a = 1'b0;
        chk("t4_valida_pos_flush", 128'(iv_a), 128'(0));
        ip_a = 1'b1;
        stream_a(64'd40, 1, 10);
        drena_a(10);
        chk("t4_entregues", 128'(n_pop_a - pops0), 128'(1));

        // 5: reset in the middle of a stream
        ip_a = 1'b0;
        stream_a(64'd300, 2, 6);
        end_a = 64'd302; ev_a = 1'b1;
        #2;
        rst_a = 1'b1;
        #1;
        chk("t5_valida_reset", 128'(iv_a), 128'(0));
        chk("t5_pronto_reset", 128'(ep_a), 128'(0));
        chk("t5_mem_ler_reset", 128'(ml_a), 128'(0));
        fila_a.delete();
        ev_a = 1'b0;
        repeat (2) @(negedge clock);
        rst_a = 1'b0;
        pops0 = n_pop_a;
        ip_a = 1'b1;
        stream_a(64'd200, 4, 20);
        drena_a(20);
        chk("t5_entregues", 128'(n_pop_a - pops0), 128'(4));

        // 6: random valid/ready/flush on the LATENCIA=2, PROFUNDIDADE=4 instance
        for (int c = 0; c < 2000; c++) begin
            ev_b   = ($urandom_range(0, 1) == 1);
            end_b  = 64'($urandom_range(0, 2047));
            if ($urandom_range(0, 7) == 0) end_b[40] = 1'b1;
            ip_b   = ($urandom_range(0, 3) != 0);
            desc_b = ($urandom_range(0, 49) == 0);
            ciclo_b(ac);
        end
        ev_b = 1'b0; desc_b = 1'b0; ip_b = 1'b1;
        for (int c = 0; c < 50 && (fila_b.size() != 0 || iv_b); c++) ciclo_b(ac);
        chk("t6_fila_vazia", 128'(fila_b.size()), 128'(0));
        chk("t6_valida", 128'(iv_b), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
